// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet test-frame generator: FSM state codes,
// the per-beat marker word, default length bounds and the length clamp helper.
package eth_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_GAP  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam logic [15:0] BEAT_MARKER = 16'hA55A;

    localparam int DEF_MIN_LEN = 60;
    localparam int DEF_MAX_LEN = 9600;

    // Flow identifiers are carried in 4 bits (up to 16 flows).
    localparam int FLOW_W = 4;

    function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                              input int min_len,
                                              input int max_len);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'(min_len);
        hi = 16'(max_len);
        if (len < lo)
            return lo;
        else if (len > hi)
            return hi;
        else
            return len;
    endfunction

endpackage

// File: rtl/eth_rr_sel.sv
// Round-robin flow picker: returns the next set bit of mask strictly after
// current, wrapping to the lowest set bit; holds current if mask is empty.
module eth_rr_sel
    import eth_pkg::*;
#(
    parameter int NUM_FLOWS = 4
) (
    input  logic [NUM_FLOWS-1:0] mask,
    input  logic [FLOW_W-1:0]    current,
    output logic [FLOW_W-1:0]    next
);

    logic [NUM_FLOWS-1:0] above_mask;
    logic                 hi_found;
    logic                 lo_found;
    logic [FLOW_W-1:0]    hi_idx;
    logic [FLOW_W-1:0]    lo_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOWS; gi++) begin : g_above
            assign above_mask[gi] = mask[gi] && (FLOW_W'(gi) > current);
        end
    endgenerate

    // Descending scan so the lowest qualifying index is the one that sticks.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NUM_FLOWS - 1; j >= 0; j--) begin
            if (mask[j]) begin
                lo_found = 1'b1;
                lo_idx   = FLOW_W'(j);
            end
            if (above_mask[j]) begin
                hi_found = 1'b1;
                hi_idx   = FLOW_W'(j);
            end
        end
        if (hi_found)
            next = hi_idx;
        else if (lo_found)
            next = lo_idx;
        else
            next = current;
    end

endmodule

// File: rtl/eth_pktgen.sv
// AXI-Stream Ethernet test-frame generator: round-robin over enabled flows,
// fixed-length frames with per-flow sequence numbers and programmable gap.
module eth_pktgen
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_FLOWS  = 4,
    parameter int MIN_LEN    = DEF_MIN_LEN,
    parameter int MAX_LEN    = DEF_MAX_LEN
) (
    input  logic                  clk156,
    input  logic                  sys_rst,
    input  logic                  enable,
    input  logic [NUM_FLOWS-1:0]  flow_mask,
    input  logic [15:0]           frame_len,
    input  logic [15:0]           ifg_cycles,
    input  logic [31:0]           frame_count,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           frames_sent
);

    localparam int HALVES = DATA_WIDTH / 64;
    localparam int KW_LOG = $clog2(KEEP_WIDTH);

    state_t                state_reg;
    logic [15:0]           beats_reg;
    logic [KEEP_WIDTH-1:0] last_keep_reg;
    logic [15:0]           ifg_reg;
    logic [31:0]           count_reg;
    logic [NUM_FLOWS-1:0]  mask_reg;
    logic [31:0]           frames_sent_reg;
    logic                  done_reg;
    logic [15:0]           beat_reg;
    logic [15:0]           gap_reg;
    logic [FLOW_W-1:0]     flow_reg;
    logic [23:0]           seq_reg [NUM_FLOWS];

    logic [15:0]           len_clamped;
    logic [15:0]           beats_calc;
    logic [KW_LOG-1:0]     rem;
    logic [KEEP_WIDTH-1:0] last_keep_calc;
    logic [FLOW_W-1:0]     start_flow;
    logic [FLOW_W-1:0]     next_flow;
    logic [23:0]           cur_seq;
    logic [31:0]           frames_next;
    logic                  last_beat;
    logic                  fire;
    logic                  frame_end;
    logic                  start;
    logic [DATA_WIDTH-1:0] word;

    // Frame geometry is derived from the live inputs but only captured at start.
    assign len_clamped    = clamp_len(frame_len, MIN_LEN, MAX_LEN);
    assign beats_calc     = 16'((32'(len_clamped) + KEEP_WIDTH - 1) >> KW_LOG);
    assign rem            = len_clamped[KW_LOG-1:0];
    assign last_keep_calc = (rem == '0) ? '1 : ~({KEEP_WIDTH{1'b1}} << rem);

    assign start       = (state_reg == ST_IDLE) && enable && (|flow_mask);
    assign last_beat   = (beat_reg == beats_reg - 16'd1);
    assign fire        = m_axis_tvalid && m_axis_tready;
    assign frame_end   = fire && last_beat;
    assign frames_next = (frames_sent_reg == 32'hFFFF_FFFF) ? frames_sent_reg
                                                            : frames_sent_reg + 32'd1;

    // Starting from the top index makes the picker return the lowest set bit.
    eth_rr_sel #(.NUM_FLOWS(NUM_FLOWS)) u_start_sel (
        .mask    (flow_mask),
        .current (FLOW_W'(NUM_FLOWS - 1)),
        .next    (start_flow)
    );

    eth_rr_sel #(.NUM_FLOWS(NUM_FLOWS)) u_next_sel (
        .mask    (mask_reg),
        .current (flow_reg),
        .next    (next_flow)
    );

    always_comb begin
        cur_seq = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            if (flow_reg == FLOW_W'(i))
                cur_seq = seq_reg[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < HALVES; gi++) begin : g_half
            logic [15:0] half_idx;
            assign half_idx = 16'(32'(beat_reg) * HALVES + gi);
            assign word[gi*64 +: 64] = {{(8 - FLOW_W){1'b0}}, flow_reg, cur_seq,
                                        half_idx, BEAT_MARKER};
        end
    endgenerate

    assign m_axis_tvalid = (state_reg == ST_SEND);
    assign m_axis_tdata  = m_axis_tvalid ? word : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? (last_beat ? last_keep_reg : '1) : '0;
    assign m_axis_tlast  = m_axis_tvalid && last_beat;
    assign m_axis_tuser  = 1'b0;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = done_reg;
    assign frames_sent   = frames_sent_reg;

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_FLOWS; i++)
                seq_reg[i] <= '0;
        end else if (frame_end) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (flow_reg == FLOW_W'(i))
                    seq_reg[i] <= seq_reg[i] + 24'd1;
            end
        end
    end

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            state_reg       <= ST_IDLE;
            beats_reg       <= '0;
            last_keep_reg   <= '0;
            ifg_reg         <= '0;
            count_reg       <= '0;
            mask_reg        <= '0;
            frames_sent_reg <= '0;
            done_reg        <= 1'b0;
            beat_reg        <= '0;
            gap_reg         <= '0;
            flow_reg        <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        beats_reg       <= beats_calc;
                        last_keep_reg   <= last_keep_calc;
                        ifg_reg         <= ifg_cycles;
                        count_reg       <= frame_count;
                        mask_reg        <= flow_mask;
                        frames_sent_reg <= '0;
                        done_reg        <= 1'b0;
                        beat_reg        <= '0;
                        flow_reg        <= start_flow;
                        state_reg       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (fire && !last_beat) begin
                        beat_reg <= beat_reg + 16'd1;
                    end else if (fire) begin
                        beat_reg        <= '0;
                        frames_sent_reg <= frames_next;
                        flow_reg        <= next_flow;
                        if (count_reg != '0 && frames_next == count_reg) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else if (!enable) begin
                            state_reg <= ST_IDLE;
                        end else if (ifg_reg == '0) begin
                            state_reg <= ST_SEND;
                        end else begin
                            gap_reg   <= ifg_reg;
                            state_reg <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    // gap_reg is loaded with a non-zero count, so this spans ifg_reg clocks.
                    if (gap_reg <= 16'd1)
                        state_reg <= enable ? ST_SEND : ST_IDLE;
                    else
                        gap_reg <= gap_reg - 16'd1;
                end
                ST_DONE: begin
                    if (!enable)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_pktgen.sv
// Scoreboard bench for eth_pktgen (64-bit data): directed frames are queued as
// expected beats and a negedge monitor pops and compares every handshake.
`timescale 1ns/1ps
module tb_eth_pktgen;

    logic        clk156 = 1'b0;
    logic        sys_rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  flow_mask = 4'b0000;
    logic [15:0] frame_len = 16'd64;
    logic [15:0] ifg_cycles = 16'd0;
    logic [31:0] frame_count = 32'd0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        busy;
    logic        done;
    logic [31:0] frames_sent;

    always #5 clk156 = ~clk156;

    eth_pktgen #(.DATA_WIDTH(64), .NUM_FLOWS(4)) dut (
        .clk156        (clk156),
        .sys_rst       (sys_rst),
        .enable        (enable),
        .flow_mask     (flow_mask),
        .frame_len     (frame_len),
        .ifg_cycles    (ifg_cycles),
        .frame_count   (frame_count),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy),
        .done          (done),
        .frames_sent   (frames_sent)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    hs_count = 0;
    int    last_gap = -1;
    int    gap_run = 0;
    bit    gap_on = 1'b0;
    bit    stall_en = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Hand-supplied geometry: total beats and last-beat keep for the frame.
    task automatic push_frame(input int flow, input int seq, input int nbeats,
                              input logic [7:0] lastkeep, input int npush);
        beat_t b;
        for (int i = 0; i < npush; i++) begin
            b.data = {8'(flow), 24'(seq), 16'(i), 16'hA55A};
            b.last = (i == nbeats - 1);
            b.keep = b.last ? lastkeep : 8'hFF;
            sb.push_back(b);
        end
    endtask

    task automatic start_run(input logic [15:0] len, input logic [15:0] ifg,
                             input logic [31:0] cnt, input logic [3:0] mask);
        frame_len   = len;
        ifg_cycles  = ifg;
        frame_count = cnt;
        flow_mask   = mask;
        enable      = 1'b1;
        @(negedge clk156); #1;
        check("first_beat_latency", m_axis_tvalid, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk156); #1;
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s: done=%b want 1 (timeout)", name, done);
        end
    endtask

    task automatic stop_run(input string name);
        int n = 0;
        enable = 1'b0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk156); #1;
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_count < target && n < 500) begin
            @(negedge clk156); #1;
            n++;
        end
        total++;
        if (hs_count < target) begin
            bad++;
            $display("FAIL wait_hs: got %0d want %0d", hs_count, target);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk156); #1;
            m_axis_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    always @(negedge clk156) begin
        beat_t exp;
        if (sys_rst) begin
            prev_stall = 1'b0;
            gap_on     = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast},
                      {1'b1, prev_beat});
            if (gap_on && m_axis_tvalid) begin
                last_gap = gap_run;
                gap_on   = 1'b0;
            end else if (gap_on) begin
                gap_run++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_count++;
                $display("beat %0d data=%h keep=%h last=%b", hs_count, m_axis_tdata,
                         m_axis_tkeep, m_axis_tlast);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %h want none", m_axis_tdata);
                end else begin
                    exp = sb.pop_front();
                    check("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, exp);
                end
                if (m_axis_tlast) begin
                    gap_on  = 1'b1;
                    gap_run = 0;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;

        // Reset state
        repeat (3) @(negedge clk156);
        #1;
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tuser", m_axis_tuser, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_frames", frames_sent, 32'd0);
        check("rst_tdata_tkeep", {m_axis_tdata, m_axis_tkeep}, 72'd0);
        sys_rst = 1'b0;
        @(negedge clk156); #1;

        // len=64, back-to-back, two frames; config changes mid-run must be ignored
        push_frame(0, 0, 8, 8'hFF, 8);
        push_frame(0, 1, 8, 8'hFF, 8);
        last_gap = -1;
        start_run(16'd64, 16'd0, 32'd2, 4'b0001);
        frame_len  = 16'd200;
        flow_mask  = 4'b1111;
        ifg_cycles = 16'd9;
        wait_done("t2_done");
        check("t2_frames", frames_sent, 32'd2);
        check("t2_done_tvalid", m_axis_tvalid, 1'b0);
        check("t2_b2b_gap", last_gap, 0);
        check("t2_sb_empty", sb.size(), 0);
        stop_run("t2_idle");

        // Short last beat, then an undersized length clamped up
        push_frame(0, 2, 8, 8'h1F, 8);
        start_run(16'd61, 16'd0, 32'd1, 4'b0001);
        wait_done("t3a_done");
        check("t3a_frames", frames_sent, 32'd1);
        stop_run("t3a_idle");
        push_frame(0, 3, 8, 8'h0F, 8);
        start_run(16'd10, 16'd0, 32'd1, 4'b0001);
        wait_done("t3b_done");
        stop_run("t3b_idle");

        // Round robin over flows 1 and 3 with a 5-clock gap
        push_frame(1, 0, 8, 8'hFF, 8);
        push_frame(3, 0, 8, 8'hFF, 8);
        push_frame(1, 1, 8, 8'hFF, 8);
        push_frame(3, 1, 8, 8'hFF, 8);
        last_gap = -1;
        start_run(16'd64, 16'd5, 32'd4, 4'b1010);
        wait_done("t4_done");
        check("t4_frames", frames_sent, 32'd4);
        check("t4_gap", last_gap, 5);
        stop_run("t4_idle");

        // Random backpressure; len=100 -> 13 beats, last keep 0x0F
        stall_en = 1'b1;
        push_frame(0, 4, 13, 8'h0F, 13);
        push_frame(0, 5, 13, 8'h0F, 13);
        push_frame(0, 6, 13, 8'h0F, 13);
        start_run(16'd100, 16'd2, 32'd3, 4'b0001);
        wait_done("t5_done");
        stall_en = 1'b0;
        check("t5_frames", frames_sent, 32'd3);
        check("t5_sb_empty", sb.size(), 0);
        stop_run("t5_idle");

        // enable dropped at beat 3 of an unlimited run: frame still completes
        push_frame(0, 7, 8, 8'hFF, 8);
        base = hs_count;
        start_run(16'd64, 16'd0, 32'd0, 4'b0001);
        wait_hs(base + 3);
        stop_run("t6_idle");
        check("t6_frames", frames_sent, 32'd1);
        check("t6_sb_empty", sb.size(), 0);

        // Reset at beat 3: output drops next cycle, counters cleared
        push_frame(0, 8, 8, 8'hFF, 3);
        base = hs_count;
        start_run(16'd64, 16'd0, 32'd0, 4'b0001);
        wait_hs(base + 3);
        sys_rst = 1'b1;
        enable  = 1'b0;
        @(negedge clk156); #1;
        check("t7_tvalid", m_axis_tvalid, 1'b0);
        check("t7_tlast", m_axis_tlast, 1'b0);
        check("t7_frames", frames_sent, 32'd0);
        check("t7_sb_empty", sb.size(), 0);
        sys_rst = 1'b0;
        @(negedge clk156); #1;

        // After reset, sequence numbers restart and the lowest enabled flow goes first
        push_frame(0, 0, 8, 8'hFF, 8);
        start_run(16'd64, 16'd0, 32'd1, 4'b1001);
        wait_done("t8_done");
        check("t8_frames", frames_sent, 32'd1);
        stop_run("t8_idle");

        check("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
